// File: rtl/keypad_number_entry.sv
`default_nettype none
//============================================================================
// Module   : keypad_number_entry
// Purpose  : Turns single-cycle keypad strobes into an editable multi-digit
//            BCD entry buffer, a committed value and a start handshake,
//            with error pulses for rejected keys.
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
// Parameters
//   DIGITS      entry buffer depth in BCD digits (1..8)
//   MIN_DIGITS  digits required before confirm is accepted (1..DIGITS)
//   CW          width of the length counter, $clog2(DIGITS+1)
// Ports
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   keydown       in   one-cycle key strobe
//   key_id[3:0]   in   scanner key id, valid with keydown
//   entry_bcd     out  digits being typed, newest digit in [3:0]
//   entry_len     out  number of digits typed
//   value_bcd     out  last committed value
//   armed         out  value committed, waiting for start
//   commit_pulse  out  one cycle: confirm accepted
//   start_pulse   out  one cycle: start accepted
//   err_pulse     out  one cycle: key rejected
// Build option
//   KEYPAD_BACKSPACE_EN  when defined, key 11 is backspace while typing;
//                        otherwise key 11 is treated as an invalid key.
//============================================================================
module keypad_number_entry #(
    parameter int DIGITS     = 4,
    parameter int MIN_DIGITS = 1,
    parameter int CW         = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  keydown,
    input  logic [3:0]            key_id,
    output logic [4*DIGITS-1:0]   entry_bcd,
    output logic [CW-1:0]         entry_len,
    output logic [4*DIGITS-1:0]   value_bcd,
    output logic                  armed,
    output logic                  commit_pulse,
    output logic                  start_pulse,
    output logic                  err_pulse
);

    localparam logic [CW-1:0] c_DIGITS_LEN = CW'(DIGITS);
    localparam logic [CW-1:0] c_MIN_LEN    = CW'(MIN_DIGITS);
    localparam logic [CW-1:0] c_ONE        = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    state_t r_state;

    //------------------------------------------------------------------------
    // Key decode: scanner id -> key function
    //------------------------------------------------------------------------
    logic                w_is_digit;
    logic [3:0]          w_digit;
    logic                w_is_start;
    logic                w_is_clear;
    logic                w_is_confirm;
    logic                w_is_bksp;
    logic [4*DIGITS-1:0] w_digit_ext;   // digit zero-extended to buffer width

    always_comb begin
        w_is_digit   = 1'b0;
        w_digit      = 4'd0;
        w_is_start   = 1'b0;
        w_is_clear   = 1'b0;
        w_is_confirm = 1'b0;
        w_is_bksp    = 1'b0;
        case (key_id)
            4'd0:    begin w_is_digit = 1'b1; w_digit = 4'd1; end
            4'd1:    begin w_is_digit = 1'b1; w_digit = 4'd2; end
            4'd2:    begin w_is_digit = 1'b1; w_digit = 4'd3; end
            4'd4:    begin w_is_digit = 1'b1; w_digit = 4'd4; end
            4'd5:    begin w_is_digit = 1'b1; w_digit = 4'd5; end
            4'd6:    begin w_is_digit = 1'b1; w_digit = 4'd6; end
            4'd8:    begin w_is_digit = 1'b1; w_digit = 4'd7; end
            4'd9:    begin w_is_digit = 1'b1; w_digit = 4'd8; end
            4'd10:   begin w_is_digit = 1'b1; w_digit = 4'd9; end
            4'd12:   begin w_is_digit = 1'b1; w_digit = 4'd0; end
            4'd13:   w_is_start   = 1'b1;
            4'd14:   w_is_clear   = 1'b1;
            4'd15:   w_is_confirm = 1'b1;
`ifdef KEYPAD_BACKSPACE_EN
            4'd11:   w_is_bksp    = 1'b1;
`endif
            default: ;  // ids 3, 7 (and 11 without backspace) are invalid
        endcase
    end

    always_comb begin
        w_digit_ext      = '0;
        w_digit_ext[3:0] = w_digit;
    end

    //------------------------------------------------------------------------
    // Entry / commit / arm state machine; every output is registered here.
    // The buffer is always zero outside ENTRY, so shifting a digit into it
    // from IDLE yields a single-digit entry.
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            entry_bcd    <= '0;
            entry_len    <= '0;
            value_bcd    <= '0;
            armed        <= 1'b0;
            commit_pulse <= 1'b0;
            start_pulse  <= 1'b0;
            err_pulse    <= 1'b0;
        end else begin
            commit_pulse <= 1'b0;
            start_pulse  <= 1'b0;
            err_pulse    <= 1'b0;

            if (keydown) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_is_digit) begin
                            entry_bcd <= (entry_bcd << 4) | w_digit_ext;
                            entry_len <= c_ONE;
                            r_state   <= ST_ENTRY;
                        end else if (!w_is_clear) begin
                            // start, confirm, backspace and invalid ids
                            err_pulse <= 1'b1;
                        end
                    end

                    ST_ENTRY: begin
                        if (w_is_digit) begin
                            if (entry_len < c_DIGITS_LEN) begin
                                entry_bcd <= (entry_bcd << 4) | w_digit_ext;
                                entry_len <= entry_len + c_ONE;
                            end else begin
                                err_pulse <= 1'b1;
                            end
                        end else if (w_is_clear) begin
                            entry_bcd <= '0;
                            entry_len <= '0;
                            r_state   <= ST_IDLE;
                        end else if (w_is_confirm) begin
                            if (entry_len >= c_MIN_LEN) begin
                                value_bcd    <= entry_bcd;
                                commit_pulse <= 1'b1;
                                entry_bcd    <= '0;
                                entry_len    <= '0;
                                armed        <= 1'b1;
                                r_state      <= ST_ARMED;
                            end else begin
                                err_pulse <= 1'b1;
                            end
`ifdef KEYPAD_BACKSPACE_EN
                        end else if (w_is_bksp) begin
                            // drop the newest digit; zero fills the top
                            entry_bcd <= entry_bcd >> 4;
                            entry_len <= entry_len - c_ONE;
                            if (entry_len == c_ONE) begin
                                r_state <= ST_IDLE;
                            end
`endif
                        end else begin
                            // start and invalid ids
                            err_pulse <= 1'b1;
                        end
                    end

                    ST_ARMED: begin
                        if (w_is_start) begin
                            start_pulse <= 1'b1;
                            armed       <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else if (w_is_clear) begin
                            armed   <= 1'b0;
                            r_state <= ST_IDLE;
                        end else if (w_is_digit) begin
                            // re-edit: the committed value stays until the
                            // next accepted confirm
                            entry_bcd <= w_digit_ext;
                            entry_len <= c_ONE;
                            armed     <= 1'b0;
                            r_state   <= ST_ENTRY;
                        end else begin
                            // confirm, backspace and invalid ids
                            err_pulse <= 1'b1;
                        end
                    end

                    default: begin
                        r_state   <= ST_IDLE;
                        entry_bcd <= '0;
                        entry_len <= '0;
                        armed     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_number_entry.sv
`default_nettype none
//============================================================================
// Module   : tb_keypad_number_entry
// Purpose  : Self-checking bench for keypad_number_entry. Directed key
//            sequences followed by random key traffic, each cycle compared
//            against a queue-based reference model of the entry rules.
// Revision : 1.0  initial release
//============================================================================
module tb_keypad_number_entry;

    localparam int DIGITS     = 4;
    localparam int MIN_DIGITS = 2;
    localparam int CW         = $clog2(DIGITS + 1);

    // key functions used by the model
    localparam int F_INVALID = -1;
    localparam int F_START   = 10;
    localparam int F_CLEAR   = 11;
    localparam int F_CONFIRM = 12;
    localparam int F_BKSP    = 13;

    logic                clk;
    logic                rst;
    logic                keydown;
    logic [3:0]          key_id;
    logic [4*DIGITS-1:0] entry_bcd;
    logic [CW-1:0]       entry_len;
    logic [4*DIGITS-1:0] value_bcd;
    logic                armed;
    logic                commit_pulse;
    logic                start_pulse;
    logic                err_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    keypad_number_entry #(
        .DIGITS     (DIGITS),
        .MIN_DIGITS (MIN_DIGITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .keydown      (keydown),
        .key_id       (key_id),
        .entry_bcd    (entry_bcd),
        .entry_len    (entry_len),
        .value_bcd    (value_bcd),
        .armed        (armed),
        .commit_pulse (commit_pulse),
        .start_pulse  (start_pulse),
        .err_pulse    (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    //------------------------------------------------------------------------
    // Reference model: typed digits kept as a queue (oldest first)
    //------------------------------------------------------------------------
    int                  m_q[$];
    logic [4*DIGITS-1:0] m_value;
    logic                m_armed;
    logic                m_commit;
    logic                m_start;
    logic                m_err;

    function automatic int key_fn(input logic [3:0] id);
        case (id)
            4'd0:  return 1;
            4'd1:  return 2;
            4'd2:  return 3;
            4'd4:  return 4;
            4'd5:  return 5;
            4'd6:  return 6;
            4'd8:  return 7;
            4'd9:  return 8;
            4'd10: return 9;
            4'd12: return 0;
            4'd13: return F_START;
            4'd14: return F_CLEAR;
            4'd15: return F_CONFIRM;
`ifdef KEYPAD_BACKSPACE_EN
            4'd11: return F_BKSP;
`endif
            default: return F_INVALID;
        endcase
    endfunction

    function automatic logic [4*DIGITS-1:0] pack_entry();
        logic [4*DIGITS-1:0] v;
        v = '0;
        foreach (m_q[i]) v = (v << 4) | (4*DIGITS)'(m_q[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_value  = '0;
        m_armed  = 1'b0;
        m_commit = 1'b0;
        m_start  = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic model_key(input logic [3:0] id);
        int f;
        f = key_fn(id);
        m_commit = 1'b0;
        m_start  = 1'b0;
        m_err    = 1'b0;
        if (f == F_INVALID) begin
            m_err = 1'b1;
        end else if (f <= 9) begin
            if (m_armed) begin
                m_armed = 1'b0;
                m_q.delete();
                m_q.push_back(f);
            end else if (m_q.size() < DIGITS) begin
                m_q.push_back(f);
            end else begin
                m_err = 1'b1;
            end
        end else if (f == F_START) begin
            if (m_armed) begin
                m_armed = 1'b0;
                m_start = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end else if (f == F_CLEAR) begin
            m_armed = 1'b0;
            m_q.delete();
        end else if (f == F_CONFIRM) begin
            if (!m_armed && m_q.size() >= MIN_DIGITS) begin
                m_value  = pack_entry();
                m_q.delete();
                m_armed  = 1'b1;
                m_commit = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end else begin
            if (!m_armed && m_q.size() > 0) void'(m_q.pop_back());
            else m_err = 1'b1;
        end
    endtask

    //------------------------------------------------------------------------
    // Checking
    //------------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs (called at a negedge), then compare the
    // registered outputs at the following negedge.
    task automatic step(input logic r, input logic kd, input logic [3:0] id);
        rst     = r;
        keydown = kd;
        key_id  = id;
        if (r) begin
            model_reset();
        end else if (kd) begin
            model_key(id);
        end else begin
            m_commit = 1'b0;
            m_start  = 1'b0;
            m_err    = 1'b0;
        end
        @(negedge clk);
        check("entry_bcd", 64'(entry_bcd),    64'(pack_entry()));
        check("entry_len", 64'(entry_len),    64'(m_q.size()));
        check("value_bcd", 64'(value_bcd),    64'(m_value));
        check("armed",     64'(armed),        64'(m_armed));
        check("commit",    64'(commit_pulse), 64'(m_commit));
        check("start",     64'(start_pulse),  64'(m_start));
        check("err",       64'(err_pulse),    64'(m_err));
        check("onehot",    64'($countones({commit_pulse, start_pulse, err_pulse}) <= 1), 64'd1);
    endtask

    task automatic key(input logic [3:0] id);
        step(1'b0, 1'b1, id);
    endtask

    logic [3:0] pick[5];

    initial begin
        rst     = 1'b1;
        keydown = 1'b0;
        key_id  = 4'd0;
        model_reset();
        @(negedge clk);

        // reset state
        step(1'b1, 1'b0, 4'd0);
        check("rst_entry", 64'(entry_bcd), 64'h0);
        check("rst_value", 64'(value_bcd), 64'h0);

        // 1,2,3 then confirm
        key(4'd0); key(4'd1); key(4'd2);
        check("dir_entry123", 64'(entry_bcd), 64'h0123);
        check("dir_len3",     64'(entry_len), 64'd3);
        key(4'd15);
        check("dir_commit",   64'(commit_pulse), 64'd1);
        check("dir_value123", 64'(value_bcd),    64'h0123);
        step(1'b0, 1'b0, 4'd15);
        check("dir_commit_1cyc", 64'(commit_pulse), 64'd0);

        // start, then start again
        key(4'd13);
        check("dir_start",     64'(start_pulse), 64'd1);
        check("dir_value_hold", 64'(value_bcd),  64'h0123);
        key(4'd13);
        check("dir_start_err", 64'(err_pulse), 64'd1);

        // overflow: 9,9,9,9,1
        key(4'd10); key(4'd10); key(4'd10); key(4'd10); key(4'd0);
        check("dir_full_entry", 64'(entry_bcd), 64'h9999);
        check("dir_full_err",   64'(err_pulse), 64'd1);
        key(4'd14);
        check("dir_clear", 64'(entry_bcd), 64'h0);

        // single digit then confirm with MIN_DIGITS=2
        key(4'd12); key(4'd15);
        check("dir_min_err",   64'(err_pulse), 64'd1);
        check("dir_min_value", 64'(value_bcd), 64'h0123);
        check("dir_min_len",   64'(entry_len), 64'd1);
        key(4'd14);

        // backspace key behaviour
        key(4'd4); key(4'd5); key(4'd11);
`ifdef KEYPAD_BACKSPACE_EN
        check("dir_bksp1", 64'(entry_bcd), 64'h0004);
        key(4'd11);
        check("dir_bksp2", 64'(entry_len), 64'd0);
`else
        check("dir_key11_err", 64'(err_pulse), 64'd1);
        check("dir_key11_keep", 64'(entry_bcd), 64'h0045);
`endif
        // invalid ids
        key(4'd3); key(4'd7);
        check("dir_invalid", 64'(err_pulse), 64'd1);

        // reset together with confirm while typing
        key(4'd14); key(4'd0); key(4'd1);
        step(1'b1, 1'b1, 4'd15);
        check("dir_rst_commit", 64'(commit_pulse), 64'd0);
        check("dir_rst_value",  64'(value_bcd),    64'h0);

        // random traffic, biased toward digits and confirm/start
        pick[0] = 4'd0; pick[1] = 4'd12; pick[2] = 4'd15;
        pick[3] = 4'd13; pick[4] = 4'd10;
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       kd;
            logic [3:0] id;
            r  = ($urandom_range(0, 149) == 0);
            kd = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 4) id = pick[$urandom_range(0, 4)];
            else                          id = 4'($urandom_range(0, 15));
            step(r, kd, id);
        end

        keydown = 1'b0;
        rst     = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
